// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, the "no producer" tag and the
// port-index-to-tag mapping used by both the arbiter and the reservation stations.
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 6;

  localparam logic [CDB_TAG_W-1:0] NO_TAG = '0;

  // Tag 0 is reserved for "value valid", so station i publishes as i+1.
  function automatic logic [CDB_TAG_W-1:0] port_to_tag(input int unsigned idx);
    return CDB_TAG_W'(idx + 1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: one-hot grant over a request vector, searching from ptr upward.
// With CDB_FIXED_PRIO_EN defined the lowest request wins and ptr is ignored.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PTR_W-1:0]   ptr_next
);

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
      end
    end
  end
`else
  logic found;
  int   idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PTR_W'((idx + 1) % NUM_SRC);
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one completed result per reservation station and
// broadcasts one winner per cycle on a registered CDB. Macro: CDB_FIXED_PRIO_EN.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      cdb_write,
  output logic signed [DATA_W-1:0]  cdb_data,
  output logic [TAG_W-1:0]          cdb_source
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]       full_p0;
  logic signed [DATA_W-1:0] data_p0 [NUM_SRC];
  logic [PTR_W-1:0]         ptr_p0;
  logic [PTR_W-1:0]         ptr_next;
  logic [NUM_SRC-1:0]       grant;
  logic [NUM_SRC-1:0]       xfer;

  logic                     vld_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic [TAG_W-1:0]         source_p1;

  // A granted buffer drains this edge, so it may be refilled on the same edge.
  assign req_ready = {NUM_SRC{!reset}} & (~full_p0 | grant);
  assign xfer      = req_valid & req_ready;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req      (full_p0),
    .ptr      (ptr_p0),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  // ---- stage p0: per-station holding buffers ----
`ifdef CDB_FIXED_PRIO_EN
  assign ptr_p0 = '0;
`else
  always_ff @(posedge clock) begin
    if (reset) ptr_p0 <= '0;
    else       ptr_p0 <= ptr_next;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      full_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (xfer[i])       full_p0[i] <= 1'b1;
        else if (grant[i]) full_p0[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer[i]) data_p0[i] <= req_data[i*DATA_W +: DATA_W];
    end
  end

  // ---- stage p1: registered CDB broadcast ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      source_p1 <= TAG_W'(NO_TAG);
    end else begin
      vld_p1 <= |grant;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant[i]) begin
          data_p1   <= data_p0[i];
          source_p1 <= TAG_W'(port_to_tag(i));
        end
      end
    end
  end

  assign cdb_write  = vld_p1;
  assign cdb_data   = data_p1;
  assign cdb_source = source_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table plus randomized
// traffic compared against a behavioural model of the CDB rules.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 6;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N-1:0]           req_valid;
  logic [N*DW-1:0]        req_data;
  logic [N-1:0]           req_ready;
  logic                   cdb_write;
  logic signed [DW-1:0]   cdb_data;
  logic [TW-1:0]          cdb_source;

  cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cdb_write  (cdb_write),
    .cdb_data   (cdb_data),
    .cdb_source (cdb_source)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       rst;
    bit [3:0] vld;
    int       d0, d1, d2, d3;
    bit [3:0] rdy;
    bit       wr;
    int       data;
    int       src;
  } vec_t;

  vec_t tbl [30];

  // Behavioural model: one-slot mailbox per station, rotating priority start.
  bit m_full [N];
  int m_buf  [N];
  int m_ptr;
  bit m_wr;
  int m_data;
  int m_src;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit [3:0] vld, input int d0, input int d1,
                              input int d2, input int d3, input bit [3:0] rdy, input bit wr,
                              input int data, input int src);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.rdy = rdy; v.wr = wr; v.data = data; v.src = src;
    return v;
  endfunction

  function automatic int model_winner();
    int start;
`ifdef CDB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (m_full[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic tick(input bit use_row, input vec_t r);
    int       win;
    bit [3:0] m_rdy;
    bit       c_rst;
    bit [3:0] c_vld;
    int       c_d [N];
    @(negedge clock);
    win = model_winner();
    for (int i = 0; i < N; i++) m_rdy[i] = !reset && (!m_full[i] || (i == win));
    chk("ready_model", req_ready, m_rdy);
    if (use_row) chk("ready_vec", req_ready, r.rdy);
    c_rst = reset;
    c_vld = req_valid;
    for (int i = 0; i < N; i++) c_d[i] = $signed(req_data[i*DW +: DW]);
    @(posedge clock);
    if (c_rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_ptr = 0; m_wr = 0; m_data = 0; m_src = 0;
    end else begin
      m_wr = (win >= 0);
      if (win >= 0) begin
        m_data = m_buf[win];
        m_src = win + 1;
        m_full[win] = 0;
        m_ptr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (c_vld[i] && m_rdy[i]) begin
          m_buf[i] = c_d[i];
          m_full[i] = 1;
        end
      end
    end
    #1;
    chk("write_model", cdb_write, m_wr);
    chk("data_model", cdb_data, m_data);
    chk("source_model", cdb_source, m_src);
    if (use_row) begin
      chk("write_vec", cdb_write, r.wr);
      chk("data_vec", cdb_data, r.data);
      chk("source_vec", cdb_source, r.src);
    end
  endtask

  task automatic drive(input bit rst, input bit [3:0] vld, input int d0, input int d1,
                       input int d2, input int d3);
    reset = rst;
    req_valid = vld;
    req_data = {d3, d2, d1, d0};
  endtask

  initial begin
    vec_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin m_full[i] = 0; m_buf[i] = 0; end
    m_ptr = 0; m_wr = 0; m_data = 0; m_src = 0;

    // reset held with all stations requesting, then single result
    tbl[0]  = mk(1, 4'hF, 0, 0, 0, 0,   4'b0000, 0, 0, 0);
    tbl[1]  = mk(1, 4'hF, 0, 0, 0, 0,   4'b0000, 0, 0, 0);
    tbl[2]  = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, 0, 0);
    tbl[3]  = mk(0, 4'h1, 25, 0, 0, 0,  4'b1111, 0, 0, 0);
    tbl[4]  = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 1, 25, 1);
    tbl[5]  = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, 25, 1);
    // collision on ports 1 and 2
    tbl[6]  = mk(0, 4'h6, 0, 21, -7, 0, 4'b1111, 0, 25, 1);
    tbl[7]  = mk(0, 4'h0, 0, 0, 0, 0,   4'b1011, 1, 21, 2);
    tbl[8]  = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 1, -7, 3);
    tbl[9]  = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, -7, 3);
    // all ports continuously valid; pointer starts at 3 after the collision
    tbl[10] = mk(0, 4'hF, 10, 11, 12, 13, 4'b1111, 0, -7, 3);
    tbl[11] = mk(0, 4'hF, 10, 11, 12, 13, 4'b1000, 1, 13, 4);
    tbl[12] = mk(0, 4'hF, 10, 11, 12, 13, 4'b0001, 1, 10, 1);
    tbl[13] = mk(0, 4'hF, 10, 11, 12, 13, 4'b0010, 1, 11, 2);
    tbl[14] = mk(0, 4'hF, 10, 11, 12, 13, 4'b0100, 1, 12, 3);
    tbl[15] = mk(0, 4'hF, 10, 11, 12, 13, 4'b1000, 1, 13, 4);
    tbl[16] = mk(0, 4'h0, 0, 0, 0, 0,   4'b0001, 1, 10, 1);
    tbl[17] = mk(0, 4'h0, 0, 0, 0, 0,   4'b0011, 1, 11, 2);
    tbl[18] = mk(0, 4'h0, 0, 0, 0, 0,   4'b0111, 1, 12, 3);
    tbl[19] = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 1, 13, 4);
    tbl[20] = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, 13, 4);
    // port 3 streams back-to-back
    tbl[21] = mk(0, 4'h8, 0, 0, 0, 100, 4'b1111, 0, 13, 4);
    tbl[22] = mk(0, 4'h8, 0, 0, 0, 101, 4'b1111, 1, 100, 4);
    tbl[23] = mk(0, 4'h8, 0, 0, 0, 102, 4'b1111, 1, 101, 4);
    tbl[24] = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 1, 102, 4);
    tbl[25] = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, 102, 4);
    // fill every port, then reset mid-operation discards everything
    tbl[26] = mk(0, 4'hF, 1, 2, 3, 4,   4'b1111, 0, 102, 4);
    tbl[27] = mk(1, 4'hF, 5, 6, 7, 8,   4'b0000, 0, 0, 0);
    tbl[28] = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, 0, 0);
    tbl[29] = mk(0, 4'h0, 0, 0, 0, 0,   4'b1111, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      drive(tbl[k].rst, tbl[k].vld, tbl[k].d0, tbl[k].d1, tbl[k].d2, tbl[k].d3);
      tick(1, tbl[k]);
    end

    // randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      tick(0, dummy);
    end

    drive(0, 4'h0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) tick(0, dummy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter and broadcaster for the Tomasulo core: the producing end of the CDB that the register file and reservation stations consume. Collects completed results from NUM_SRC reservation stations through per-station valid/ready handshakes, buffers one result per station, and broadcasts one winner per cycle on a registered CDB. The winner is chosen round-robin, and each result carries its producer tag.

## Interface
- NUM_SRC, 4: number of producing reservation stations. Port i owns tag i+1.
- DATA_W, 32: result width, signed two's complement.
- TAG_W, 6: CDB source-tag width. Tag 0 means "no producer / value valid" and is never broadcast.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_SRC  station i has a result to publish.
- req_data  in  NUM_SRC*DATA_W  result of station i in bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_SRC  station i may transfer this cycle.
- cdb_write  out  1  broadcast valid; drives the register file write input.
- cdb_data  out  DATA_W  broadcast value.
- cdb_source  out  TAG_W  tag of the producing station (i+1).

## Operation
- Per-port one-entry holding buffer: full flag plus data register.
- Transfer on port i: req_valid[i] && req_ready[i] at a rising edge. The buffer loads req_data and sets full.
- Arbitration is evaluated from registered state only, using buffer full flags: exactly one full buffer is granted per cycle, or none.
- Round-robin priority pointer ptr: search order ptr, ptr+1, …, wrapping mod NUM_SRC. After a grant to i, ptr becomes (i+1) mod NUM_SRC. ptr holds when there is no grant.
- On a grant to i, at the next edge: cdb_write=1, cdb_data=buffer[i], cdb_source=i+1, and buffer i is cleared. This happens unless the same edge refills it (see ready).
- No grant: cdb_write=0; cdb_data and cdb_source hold their last values.
- req_ready[i] = !reset && (!full[i] || grant[i]). A granted buffer accepts a new result on the same edge it drains, which allows back-to-back results from one station.
- Simultaneous drain and refill of port i: the new data is stored and full stays 1.
- When all ports are full every cycle, each port is granted exactly once per NUM_SRC cycles.

## Timing
- Reset values: cdb_write=0, cdb_data=0, cdb_source=0, all full=0, ptr=0. req_ready is all 0 while reset is high and all 1 in the first cycle after reset.
- Latency: a result accepted at edge N appears on the CDB at the earliest after edge N+1, for one cycle. Worst case is edge N+NUM_SRC.
- cdb_write is a single-cycle pulse per broadcast. Consecutive broadcasts produce consecutive cycles with cdb_write=1.
- Reset mid-operation: all buffered results are discarded, and no broadcast occurs on the edge where reset is sampled high.
- req_data is sampled only on a transfer edge. There is no stability requirement on it otherwise.
- No combinational path from req_valid or req_data to any cdb_* output.

## Configuration
- CDB_FIXED_PRIO_EN defined: the lowest full index always wins and the ptr register is removed. Starvation of high indices is permitted.
- CDB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Structure
- Shared package cdb_pkg holds:
  - DATA_W and TAG_W defaults.
  - NO_TAG = 0.
  - A function mapping port index to tag (i+1), also used by the reservation stations.
- One sub-module, rr_arbiter: takes a NUM_SRC-bit request vector and the pointer, and returns a one-hot grant plus the next pointer. The fixed-priority variant is selected inside it under CDB_FIXED_PRIO_EN.

## Test plan
- Reset: hold reset 2 cycles with req_valid=all 1 -> req_ready=0, cdb_write=0, cdb_data=0, cdb_source=0. One cycle after release -> req_ready=4'b1111.
- Single result: port 0 sends 25 at edge N -> after edge N+1, cdb_write=1, cdb_data=25, cdb_source=1, for exactly one cycle.
- Collision: ports 1 and 2 send 21 and -7 on the same edge -> two consecutive broadcasts, (21, tag 2) then (-7, tag 3). Pointer ends at 3.
- Fairness: all four ports held valid continuously with distinct values -> tags cycle 1,2,3,4,1,… and cdb_write stays 1 every cycle.
- Back-to-back single port: port 3 streams 100,101,102 with req_valid held high -> req_ready stays 1, and the CDB shows tag 4 with 100,101,102 on consecutive cycles.
- Reset mid-operation: ports 0–3 full, assert reset for 1 cycle -> no broadcast follows, and cdb_data=0 after the reset edge.
